// File: rtl/timing_decoder_if.sv
// timing_decoder_if: control-unit side bundle of the timing decoder.
// Inputs to the decoder: start, halt, seq_inc, seq_clr, ir_outdata.
// Outputs from the decoder: times, opcode, indirect, run, instr_count, seq_err.
// The master modport is the control unit/user side; the slave modport is the decoder.
interface timing_decoder_if #(
   parameter int SC_W   = 4,
   parameter int ICNT_W = 16
);
   logic                 start;
   logic                 halt;
   logic                 seq_inc;
   logic                 seq_clr;
   logic [15:0]          ir_outdata;
   logic [2**SC_W-1:0]   times;
   logic [7:0]           opcode;
   logic                 indirect;
   logic                 run;
   logic [ICNT_W-1:0]    instr_count;
   logic                 seq_err;
   modport master (
      output start, halt, seq_inc, seq_clr, ir_outdata,
      input  times, opcode, indirect, run, instr_count, seq_err
   );
   modport slave (
      input  start, halt, seq_inc, seq_clr, ir_outdata,
      output times, opcode, indirect, run, instr_count, seq_err
   );
endinterface

// File: rtl/timing_decoder.sv
// timing_decoder: sequence counter, run flip-flop and instruction decoder of the basic computer.
// Ports: clk (rising edge), reset (asynchronous, active-low),
//        bus (timing_decoder_if.slave): start/halt/seq_inc/seq_clr/ir_outdata in,
//        times (one-hot of sc)/opcode/indirect/run/instr_count/seq_err out.
// Optional feature macro SEQ_WRAP_GUARD_EN: seq_inc at the last sc state holds sc,
// sets the sticky seq_err and stops run; without it sc wraps and seq_err stays 0.
module timing_decoder #(
   parameter int SC_W   = 4,
   parameter int ICNT_W = 16
) (
   input logic             clk,
   input logic             reset,
   timing_decoder_if.slave bus
);
   logic [SC_W-1:0]   r_sc;
   logic              r_run;
   logic              r_indirect;
   logic              r_err;
   logic [7:0]        r_opcode;
   logic [ICNT_W-1:0] r_icnt;
   logic              w_clr;
   logic              w_inc;
   logic              w_t2;
   logic              w_ovf;
   // halt clears the counter exactly like seq_clr and also suppresses the T2 capture
   assign w_clr = bus.halt | bus.seq_clr;
   assign w_inc = bus.seq_inc & r_run;
   assign w_t2  = r_run & (r_sc == SC_W'(2)) & ~w_clr;
`ifdef SEQ_WRAP_GUARD_EN
   assign w_ovf = w_inc & ~w_clr & (r_sc == {SC_W{1'b1}});
`else
   assign w_ovf = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_sc       <= '0;
         r_run      <= 1'b0;
         r_indirect <= 1'b0;
         r_err      <= 1'b0;
         r_opcode   <= '0;
         r_icnt     <= '0;
      end else begin
         r_sc  <= w_clr ? '0 : (w_inc & ~w_ovf) ? r_sc + SC_W'(1) : r_sc;
         r_run <= (bus.halt | w_ovf) ? 1'b0 : (bus.start | r_run);
         r_err <= r_err | w_ovf;
         if (w_t2) begin
            r_opcode   <= 8'b1 << bus.ir_outdata[14:12];
            r_indirect <= bus.ir_outdata[15];
            r_icnt     <= r_icnt + ICNT_W'(1);
         end
      end
   assign bus.times       = {{(2**SC_W-1){1'b0}}, 1'b1} << r_sc;
   assign bus.opcode      = r_opcode;
   assign bus.indirect    = r_indirect;
   assign bus.run         = r_run;
   assign bus.instr_count = r_icnt;
   assign bus.seq_err     = r_err;
endmodule

// File: tb/tb_timing_decoder.sv
// tb_timing_decoder: directed and randomized checks of timing_decoder against a behavioural model.
module tb_timing_decoder;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   int m_sc, m_cnt;
   logic m_run, m_ind, m_err;
   logic [7:0] m_op;
   timing_decoder_if b();
   timing_decoder dut (.clk(clk), .reset(reset), .bus(b));
   always #5 clk = ~clk;

   function automatic logic [42:0] dut_v();
      return {b.times, b.opcode, b.indirect, b.run, b.instr_count, b.seq_err};
   endfunction

   function automatic logic [42:0] mdl_v();
      return {16'(32'd1 << m_sc), m_op, m_ind, m_run, 16'(m_cnt), m_err};
   endfunction

   task automatic mreset();
      m_sc = 0; m_cnt = 0; m_run = 0; m_ind = 0; m_err = 0; m_op = 8'h00;
   endtask

   // advance the model by the rules for one edge using the inputs now applied, then clock the DUT
   task automatic cyc();
      bit ovf = 0;
      bit cap = m_run && m_sc == 2 && !b.halt && !b.seq_clr;
`ifdef SEQ_WRAP_GUARD_EN
      ovf = m_run && b.seq_inc && !b.seq_clr && !b.halt && m_sc == 15;
`endif
      if (cap) begin
         m_op = 8'(1 << b.ir_outdata[14:12]);
         m_ind = b.ir_outdata[15];
         m_cnt = (m_cnt + 1) % 65536;
      end
      if (b.halt || b.seq_clr) m_sc = 0;
      else if (b.seq_inc && m_run) m_sc = ovf ? 15 : (m_sc + 1) % 16;
      if (b.halt || ovf) m_run = 0;
      else if (b.start) m_run = 1;
      if (ovf) m_err = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      b.start = 0; b.halt = 0; b.seq_inc = 0; b.seq_clr = 0; b.ir_outdata = 16'h0000;
      reset = 0; mreset();
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (b.times !== 16'h0001 || b.opcode !== 8'h00 || b.run !== 1'b0) begin
         errors++; $display("FAIL reset_vals: times=%h opcode=%h run=%b, want 0001 00 0", b.times, b.opcode, b.run);
      end
      checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL reset_model: got %h want %h", dut_v(), mdl_v()); end
      reset = 1; cyc();
      b.start = 1; cyc(); b.start = 0;
      checks++;
      if (b.run !== 1'b1 || b.times !== 16'h0001) begin
         errors++; $display("FAIL start_run: run=%b times=%h, want 1 0001", b.run, b.times);
      end
   endtask

   task automatic test_fetch_decode();
      logic [15:0] exp_t;
      b.ir_outdata = 16'h9123; b.seq_inc = 1;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         exp_t = 16'h0001 << i;
         checks++;
         if (b.times !== exp_t) begin errors++; $display("FAIL fetch_times%0d: got %h want %h", i, b.times, exp_t); end
      end
      b.seq_inc = 0;
      checks++;
      if (b.opcode !== 8'h02 || b.indirect !== 1'b1 || b.instr_count !== 16'd1) begin
         errors++; $display("FAIL fetch_decode: op=%h ind=%b cnt=%0d, want 02 1 1", b.opcode, b.indirect, b.instr_count);
      end
      checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL fetch_model: got %h want %h", dut_v(), mdl_v()); end
   endtask

   task automatic test_register_ref();
      b.seq_clr = 1; cyc(); b.seq_clr = 0;
      b.ir_outdata = 16'h7800; b.seq_inc = 1;
      repeat (3) cyc();
      b.seq_inc = 0;
      checks++;
      if (b.opcode !== 8'h80 || b.indirect !== 1'b0 || b.times !== 16'h0008 || b.instr_count !== 16'd2) begin
         errors++; $display("FAIL regref_decode: op=%h ind=%b times=%h cnt=%0d, want 80 0 0008 2", b.opcode, b.indirect, b.times, b.instr_count);
      end
      b.seq_clr = 1; cyc(); b.seq_clr = 0;
      checks++;
      if (b.times !== 16'h0001 || b.opcode !== 8'h80) begin
         errors++; $display("FAIL regref_clr: times=%h op=%h, want 0001 80", b.times, b.opcode);
      end
   endtask

   task automatic test_priority();
      b.ir_outdata = 16'h2010; b.seq_inc = 1;
      repeat (5) cyc();
      checks++;
      if (b.times !== 16'h0020) begin errors++; $display("FAIL prio_t5: times=%h want 0020", b.times); end
      b.seq_clr = 1; cyc(); b.seq_clr = 0; b.seq_inc = 0;
      checks++;
      if (b.times !== 16'h0001) begin errors++; $display("FAIL prio_clr_inc: times=%h want 0001", b.times); end
      b.seq_inc = 1; cyc(); b.seq_inc = 0;
      b.start = 1; b.halt = 1; cyc(); b.start = 0; b.halt = 0;
      checks++;
      if (b.run !== 1'b0 || b.times !== 16'h0001) begin
         errors++; $display("FAIL prio_halt_start: run=%b times=%h, want 0 0001", b.run, b.times);
      end
      b.seq_inc = 1; repeat (2) cyc(); b.seq_inc = 0;
      checks++;
      if (b.times !== 16'h0001 || b.run !== 1'b0) begin
         errors++; $display("FAIL prio_inc_halted: times=%h run=%b, want 0001 0", b.times, b.run);
      end
      checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL prio_model: got %h want %h", dut_v(), mdl_v()); end
   endtask

   task automatic test_overflow();
      b.start = 1; cyc(); b.start = 0;
      b.seq_inc = 1; repeat (16) cyc(); b.seq_inc = 0;
`ifdef SEQ_WRAP_GUARD_EN
      checks++;
      if (b.times !== 16'h8000 || b.seq_err !== 1'b1 || b.run !== 1'b0) begin
         errors++; $display("FAIL ovf_guard: times=%h err=%b run=%b, want 8000 1 0", b.times, b.seq_err, b.run);
      end
`else
      checks++;
      if (b.times !== 16'h0001 || b.seq_err !== 1'b0 || b.run !== 1'b1) begin
         errors++; $display("FAIL ovf_wrap: times=%h err=%b run=%b, want 0001 0 1", b.times, b.seq_err, b.run);
      end
`endif
      checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL ovf_model: got %h want %h", dut_v(), mdl_v()); end
      b.halt = 1; cyc(); b.halt = 0;
   endtask

   task automatic test_async_reset();
      b.start = 1; cyc(); b.start = 0;
      b.ir_outdata = 16'h6040; b.seq_inc = 1;
      repeat (4) cyc();
      b.seq_inc = 0;
      checks++;
      if (b.times !== 16'h0010 || b.opcode !== 8'h40) begin
         errors++; $display("FAIL areset_pre: times=%h op=%h, want 0010 40", b.times, b.opcode);
      end
      reset = 0; #1;
      mreset();
      checks++;
      if (dut_v() !== {16'h0001, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
         errors++; $display("FAIL areset_now: got %h want reset values", dut_v());
      end
      #3 reset = 1;
      b.seq_inc = 1; b.ir_outdata = 16'h1234;
      repeat (4) cyc();
      b.seq_inc = 0;
      checks++;
      if (b.instr_count !== 16'd0 || b.run !== 1'b0 || b.opcode !== 8'h00 || b.times !== 16'h0001) begin
         errors++; $display("FAIL areset_nocap: cnt=%0d run=%b op=%h times=%h, want 0 0 00 0001", b.instr_count, b.run, b.opcode, b.times);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         b.start = ($urandom_range(0, 19) == 0);
         b.halt = ($urandom_range(0, 39) == 0);
         b.seq_clr = ($urandom_range(0, 5) == 0);
         b.seq_inc = ($urandom_range(0, 3) != 0);
         b.ir_outdata = 16'($urandom);
         cyc();
         checks++;
         if (dut_v() !== mdl_v()) begin errors++; $display("FAIL rand_%0d: got %h want %h", i, dut_v(), mdl_v()); end
      end
      b.start = 0; b.halt = 0; b.seq_clr = 0; b.seq_inc = 0;
   endtask

   initial begin
      test_reset();
      test_fetch_decode();
      test_register_ref();
      test_priority();
      test_overflow();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
